adc_spi_responder: RTL and testbench

SPI slave that acts as the far end of the ADC SPI link: it emulates the external 4-channel ADC, answering the ADC interface's SPI master with 16-bit samples taken from parallel inputs. It sits in the FPGA hardware-in-the-loop build, where samples come from the plant model or a pattern generator, and in the verification environment as the ADC model. All SPI pins are sampled in the system clock domain, so no SCK clock domain exists.

---
 rtl/adc_spi_pkg.sv | 17 +
 rtl/spi_pin_sync.sv | 46 ++++
 rtl/adc_spi_responder.sv | 167 ++++++++++++++++
 tb/tb_adc_spi_responder.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
// Shared constants and FSM state type for the ADC SPI responder.
package adc_spi_pkg;

  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned DATA_FIRST = 16;
  localparam logic [1:0]  CMD_VALID  = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StGap,
    StData,
    StTail
  } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes SCK, MOSI and CS_n into clk_i and produces single-cycle edge strobes.
module spi_pin_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sck_i,
  input  logic mosi_i,
  input  logic cs_n_i,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic cs_fall_o,
  output logic cs_rise_o,
  output logic mosi_o
);

  logic [SyncStages-1:0] sck_sync_q;
  logic [SyncStages-1:0] mosi_sync_q;
  logic [SyncStages-1:0] cs_sync_q;
  logic                  sck_prev_q;
  logic                  cs_prev_q;

  // CS_n chain resets low so a CS_n already low at reset release yields no falling edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SyncStages-2:0], sck_i};
      mosi_sync_q <= {mosi_sync_q[SyncStages-2:0], mosi_i};
      cs_sync_q   <= {cs_sync_q[SyncStages-2:0], cs_n_i};
      sck_prev_q  <= sck_sync_q[SyncStages-1];
      cs_prev_q   <= cs_sync_q[SyncStages-1];
    end
  end

  assign sck_rise_o = sck_sync_q[SyncStages-1] & ~sck_prev_q;
  assign sck_fall_o = ~sck_sync_q[SyncStages-1] & sck_prev_q;
  assign cs_rise_o  = cs_sync_q[SyncStages-1] & ~cs_prev_q;
  assign cs_fall_o  = ~cs_sync_q[SyncStages-1] & cs_prev_q;
  assign mosi_o     = mosi_sync_q[SyncStages-1];

endmodule

// File: rtl/adc_spi_responder.sv
// SPI mode-0 slave emulating a 4-channel ADC: 8-bit command, 8 gap bits, 16-bit sample.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                spi_sck,
  input  logic                spi_mosi,
  input  logic                spi_cs_n,
  output logic                spi_miso,
  output logic                spi_miso_oe,
  input  logic [4*DATA_W-1:0] sample_in,
  output logic [1:0]          cmd_chan,
  output logic                frame_done,
  output logic                frame_err,
  output logic                cmd_bad
);

  localparam logic [4:0] CmdLast  = 5'(CMD_BITS - 1);
  localparam logic [4:0] GapLast  = 5'(DATA_FIRST - 1);
  localparam logic [4:0] DataLast = 5'(FRAME_BITS - 1);

  logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;

  spi_pin_sync #(
    .SyncStages (SYNC_STAGES)
  ) u_pin_sync (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .sck_i      (spi_sck),
    .mosi_i     (spi_mosi),
    .cs_n_i     (spi_cs_n),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .cs_fall_o  (cs_fall),
    .cs_rise_o  (cs_rise),
    .mosi_o     (mosi_s)
  );

  logic [DATA_W-1:0] chan_sample [4];
  for (genvar k = 0; k < 4; k++) begin : g_chan
    assign chan_sample[k] = sample_in[k*DATA_W +: DATA_W];
  end

  state_e            state_q, state_d;
  logic [4:0]        bitcnt_q, bitcnt_d;
  logic [6:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic [1:0]        chan_q, chan_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              bad_q, bad_d;
  logic [7:0]        cmd_full;

  assign cmd_full = {cmd_q, mosi_s};

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    cmd_d    = cmd_q;
    shreg_d  = shreg_q;
    miso_d   = miso_q;
    oe_d     = oe_q;
    chan_d   = chan_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    bad_d    = 1'b0;

    // CS_n rising overrides any coincident SCK edge. A rise seen in idle belongs to a
    // frame we never entered (e.g. CS_n low across reset) and is not reported.
    if (cs_rise) begin
      if (state_q != StIdle) begin
        done_d = (state_q == StTail);
        err_d  = (state_q != StTail);
      end
      state_d  = StIdle;
      oe_d     = 1'b0;
      miso_d   = 1'b0;
      bitcnt_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_d  = StCmd;
            oe_d     = 1'b1;
            miso_d   = 1'b0;
            bitcnt_d = '0;
          end
        end
        StCmd: begin
          if (sck_rise) begin
            bitcnt_d = bitcnt_q + 5'd1;
            cmd_d    = cmd_full[6:0];
            if (bitcnt_q == CmdLast) begin
              state_d = StGap;
              if (cmd_full[7:6] == CMD_VALID) begin
                shreg_d = chan_sample[cmd_full[1:0]];
                chan_d  = cmd_full[1:0];
              end else begin
                shreg_d = '0;
                bad_d   = 1'b1;
              end
            end
          end
        end
        StGap: begin
          if (sck_rise) begin
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == GapLast) state_d = StData;
          end
        end
        StData: begin
          if (sck_rise) begin
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == DataLast) state_d = StTail;
          end else if (sck_fall) begin
            miso_d  = shreg_q[DATA_W-1];
            shreg_d = shreg_q << 1;
          end
        end
        StTail: begin
          if (sck_fall) miso_d = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      bitcnt_q <= '0;
      cmd_q    <= '0;
      shreg_q  <= '0;
      miso_q   <= 1'b0;
      oe_q     <= 1'b0;
      chan_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      cmd_q    <= cmd_d;
      shreg_q  <= shreg_d;
      miso_q   <= miso_d;
      oe_q     <= oe_d;
      chan_q   <= chan_d;
      done_q   <= done_d;
      err_q    <= err_d;
      bad_q    <= bad_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign cmd_chan    = chan_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign cmd_bad     = bad_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder acting as an SPI master at clk/8.
module tb_adc_spi_responder;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        spi_sck   = 1'b0;
  logic        spi_mosi  = 1'b0;
  logic        spi_cs_n  = 1'b1;
  logic [63:0] sample_in = '0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [1:0]  cmd_chan;
  logic        frame_done;
  logic        frame_err;
  logic        cmd_bad;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_err  = 0;
  int n_bad  = 0;

  always #10 clk = ~clk;

  adc_spi_responder #(
    .DATA_W      (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_cs_n    (spi_cs_n),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .sample_in   (sample_in),
    .cmd_chan    (cmd_chan),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .cmd_bad     (cmd_bad)
  );

  always @(negedge clk) begin
    if (frame_done) n_done++;
    if (frame_err)  n_err++;
    if (cmd_bad)    n_bad++;
  end

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // MISO is sampled just before each SCK rising pin edge, as a mode-0 master does.
  task automatic spi_frame(input logic [7:0] cmd, input int nbits, input bit end_cs,
                           output logic [39:0] rx, output bit oe_ok);
    logic [7:0] sh;
    sh       = cmd;
    rx       = '0;
    oe_ok    = 1'b1;
    spi_sck  = 1'b0;
    spi_cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 8) ? sh[7] : 1'b0;
      sh       = sh << 1;
      clocks(4);
      rx[i] = spi_miso;
      if (spi_miso_oe !== 1'b1) oe_ok = 1'b0;
      spi_sck = 1'b1;
      clocks(4);
      spi_sck = 1'b0;
    end
    clocks(4);
    if (end_cs) spi_cs_n = 1'b1;
  endtask

  function automatic logic [15:0] data_word(input logic [39:0] rx);
    logic [15:0] w;
    for (int k = 0; k < 16; k++) w[15-k] = rx[16+k];
    return w;
  endfunction

  task automatic test_reset();
    clocks(2);
    checks++;
    if ({spi_miso, spi_miso_oe, cmd_chan} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got miso=%b oe=%b chan=%0d, expected 0/0/0",
               spi_miso, spi_miso_oe, cmd_chan);
    end
    rst_n = 1'b1;
    clocks(6);
    checks++;
    if (n_done + n_err + n_bad != 0 || spi_miso_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got pulses=%0d oe=%b, expected 0 and 0",
               n_done + n_err + n_bad, spi_miso_oe);
    end
  endtask

  task automatic test_valid_read();
    logic [39:0] rx;
    bit          ok;
    int          d0, e0;
    sample_in = {16'h0F0F, 16'hA5C3, 16'h1111, 16'h2222};
    d0 = n_done;
    e0 = n_err;
    spi_frame(8'h82, 32, 1'b1, rx, ok);
    clocks(6);
    checks++;
    if (data_word(rx) !== 16'hA5C3) begin
      errors++;
      $display("FAIL valid_data: got %h expected a5c3", data_word(rx));
    end
    checks++;
    if (rx[15:0] !== 16'h0000) begin
      errors++;
      $display("FAIL valid_head_zero: got %h expected 0000", rx[15:0]);
    end
    checks++;
    if (cmd_chan !== 2'd2) begin
      errors++;
      $display("FAIL valid_chan: got %0d expected 2", cmd_chan);
    end
    checks++;
    if (n_done - d0 != 1 || n_err - e0 != 0) begin
      errors++;
      $display("FAIL valid_pulses: got done=%0d err=%0d expected 1/0", n_done - d0, n_err - e0);
    end
    checks++;
    if (!ok || spi_miso_oe !== 1'b0) begin
      errors++;
      $display("FAIL valid_oe: got in_frame_ok=%0d after=%b expected 1/0", ok, spi_miso_oe);
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] rx;
    bit          ok;
    int          d0, e0;
    logic [15:0] exp_w [4];
    exp_w     = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    sample_in = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
    d0 = n_done;
    e0 = n_err;
    for (int c = 0; c < 4; c++) begin
      spi_frame(8'h80 + 8'(c), 32, 1'b1, rx, ok);
      checks++;
      if (data_word(rx) !== exp_w[c] || cmd_chan !== 2'(c)) begin
        errors++;
        $display("FAIL b2b_ch%0d: got data=%h chan=%0d expected %h/%0d",
                 c, data_word(rx), cmd_chan, exp_w[c], c);
      end
      clocks(2);
    end
    clocks(6);
    checks++;
    if (n_done - d0 != 4 || n_err - e0 != 0) begin
      errors++;
      $display("FAIL b2b_pulses: got done=%0d err=%0d expected 4/0", n_done - d0, n_err - e0);
    end
  endtask

  task automatic test_bad_cmd();
    logic [39:0] rx;
    bit          ok;
    int          d0, b0;
    d0 = n_done;
    b0 = n_bad;
    spi_frame(8'h42, 32, 1'b1, rx, ok);
    clocks(6);
    checks++;
    if (rx[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL bad_miso: got %h expected 00000000", rx[31:0]);
    end
    checks++;
    if (cmd_chan !== 2'd3) begin
      errors++;
      $display("FAIL bad_chan: got %0d expected 3", cmd_chan);
    end
    checks++;
    if (n_bad - b0 != 1 || n_done - d0 != 1) begin
      errors++;
      $display("FAIL bad_pulses: got bad=%0d done=%0d expected 1/1", n_bad - b0, n_done - d0);
    end
  endtask

  task automatic test_early_abort();
    logic [39:0] rx;
    bit          ok;
    int          d0, e0;
    d0 = n_done;
    e0 = n_err;
    spi_frame(8'h83, 20, 1'b0, rx, ok);
    spi_cs_n = 1'b1;
    clocks(2);
    checks++;
    if (spi_miso_oe !== 1'b1) begin
      errors++;
      $display("FAIL abort_oe_early: got %b expected 1", spi_miso_oe);
    end
    clocks(1);
    checks++;
    if (spi_miso_oe !== 1'b0) begin
      errors++;
      $display("FAIL abort_oe_drop: got %b expected 0", spi_miso_oe);
    end
    clocks(4);
    checks++;
    if (n_err - e0 != 1 || n_done - d0 != 0) begin
      errors++;
      $display("FAIL abort_pulses: got err=%0d done=%0d expected 1/0", n_err - e0, n_done - d0);
    end
    d0 = n_done;
    spi_frame(8'h81, 32, 1'b1, rx, ok);
    clocks(6);
    checks++;
    if (data_word(rx) !== 16'h5678 || n_done - d0 != 1) begin
      errors++;
      $display("FAIL abort_next: got data=%h done=%0d expected 5678/1",
               data_word(rx), n_done - d0);
    end
  endtask

  task automatic test_overrun();
    logic [39:0] rx;
    bit          ok;
    int          d0, e0;
    d0 = n_done;
    e0 = n_err;
    spi_frame(8'h80, 40, 1'b1, rx, ok);
    clocks(6);
    checks++;
    if (rx[39:32] !== 8'h00 || data_word(rx) !== 16'h1234) begin
      errors++;
      $display("FAIL overrun_miso: got tail=%h data=%h expected 00/1234",
               rx[39:32], data_word(rx));
    end
    checks++;
    if (n_done - d0 != 1 || n_err - e0 != 0) begin
      errors++;
      $display("FAIL overrun_pulses: got done=%0d err=%0d expected 1/0", n_done - d0, n_err - e0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [39:0] rx;
    bit          ok;
    int          p0, d0;
    spi_frame(8'h83, 24, 1'b0, rx, ok);
    checks++;
    if (cmd_chan !== 2'd3 || spi_miso_oe !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got chan=%0d oe=%b expected 3/1", cmd_chan, spi_miso_oe);
    end
    rst_n = 1'b0;
    clocks(1);
    checks++;
    if ({spi_miso, spi_miso_oe, cmd_chan} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_outputs: got miso=%b oe=%b chan=%0d expected 0/0/0",
               spi_miso, spi_miso_oe, cmd_chan);
    end
    clocks(1);
    rst_n = 1'b1;
    p0 = n_done + n_err + n_bad;
    for (int i = 0; i < 4; i++) begin
      clocks(4);
      spi_sck = 1'b1;
      clocks(4);
      spi_sck = 1'b0;
    end
    clocks(4);
    checks++;
    if (spi_miso_oe !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle_oe: got %b expected 0", spi_miso_oe);
    end
    spi_cs_n = 1'b1;
    clocks(6);
    checks++;
    if (n_done + n_err + n_bad - p0 != 0) begin
      errors++;
      $display("FAIL rst_no_pulses: got %0d expected 0", n_done + n_err + n_bad - p0);
    end
    d0 = n_done;
    spi_frame(8'h83, 32, 1'b1, rx, ok);
    clocks(6);
    checks++;
    if (data_word(rx) !== 16'hDEF0 || n_done - d0 != 1 || cmd_chan !== 2'd3) begin
      errors++;
      $display("FAIL rst_next: got data=%h done=%0d chan=%0d expected def0/1/3",
               data_word(rx), n_done - d0, cmd_chan);
    end
  endtask

  initial begin
    test_reset();
    test_valid_read();
    test_back_to_back();
    test_bad_cmd();
    test_early_abort();
    test_overrun();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
